// File: rtl/conv_pkg.sv
// Shared constants for the convolution accelerator:
// layer state codes, layer output sizes and bus widths.
package conv_pkg;

    localparam int STATE_DATAWIDTH   = 4;
    localparam int ADDRESS_DATAWIDTH = 13;

    localparam int CONV1_1_OUTPUT_SIZE = 82;
    localparam int CONV1_2_OUTPUT_SIZE = 80;
    localparam int CONV2_1_OUTPUT_SIZE = 38;
    localparam int CONV2_2_OUTPUT_SIZE = 36;
    localparam int CONV3_1_OUTPUT_SIZE = 16;
    localparam int CONV3_2_OUTPUT_SIZE = 14;

    localparam logic [STATE_DATAWIDTH-1:0] IDLE    = 4'd0;
    localparam logic [STATE_DATAWIDTH-1:0] LOAD    = 4'd1;
    localparam logic [STATE_DATAWIDTH-1:0] CONV1_1 = 4'd2;
    localparam logic [STATE_DATAWIDTH-1:0] CONV1_2 = 4'd3;
    localparam logic [STATE_DATAWIDTH-1:0] POOL1   = 4'd4;
    localparam logic [STATE_DATAWIDTH-1:0] CONV2_1 = 4'd5;
    localparam logic [STATE_DATAWIDTH-1:0] CONV2_2 = 4'd6;
    localparam logic [STATE_DATAWIDTH-1:0] POOL2   = 4'd7;
    localparam logic [STATE_DATAWIDTH-1:0] CONV3_1 = 4'd8;
    localparam logic [STATE_DATAWIDTH-1:0] CONV3_2 = 4'd9;
    localparam logic [STATE_DATAWIDTH-1:0] POOL3   = 4'd10;
    localparam logic [STATE_DATAWIDTH-1:0] FC      = 4'd11;
    localparam logic [STATE_DATAWIDTH-1:0] FINISH  = 4'd12;

endpackage

// File: rtl/conv_addr_counter.sv
// Conv output address counter: wraps at the last pixel of
// the current conv layer, zero outside conv layers.
module conv_addr_counter #(
    parameter int STATE_DATAWIDTH     = conv_pkg::STATE_DATAWIDTH,
    parameter int ADDRESS_DATAWIDTH   = conv_pkg::ADDRESS_DATAWIDTH,
    parameter int CONV1_1_OUTPUT_SIZE = conv_pkg::CONV1_1_OUTPUT_SIZE,
    parameter int CONV1_2_OUTPUT_SIZE = conv_pkg::CONV1_2_OUTPUT_SIZE,
    parameter int CONV2_1_OUTPUT_SIZE = conv_pkg::CONV2_1_OUTPUT_SIZE,
    parameter int CONV2_2_OUTPUT_SIZE = conv_pkg::CONV2_2_OUTPUT_SIZE,
    parameter int CONV3_1_OUTPUT_SIZE = conv_pkg::CONV3_1_OUTPUT_SIZE,
    parameter int CONV3_2_OUTPUT_SIZE = conv_pkg::CONV3_2_OUTPUT_SIZE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [STATE_DATAWIDTH-1:0]   state,
    input  logic                         out_valid,
    input  logic                         clear,
    output logic [ADDRESS_DATAWIDTH-1:0] Out_Address
);
    import conv_pkg::*;

    localparam int AW = ADDRESS_DATAWIDTH;

    // Products are formed at int width, then cut to the bus width
    localparam logic [AW-1:0] END1_1 =
        AW'(CONV1_1_OUTPUT_SIZE * CONV1_1_OUTPUT_SIZE - 1);
    localparam logic [AW-1:0] END1_2 =
        AW'(CONV1_2_OUTPUT_SIZE * CONV1_2_OUTPUT_SIZE - 1);
    localparam logic [AW-1:0] END2_1 =
        AW'(CONV2_1_OUTPUT_SIZE * CONV2_1_OUTPUT_SIZE - 1);
    localparam logic [AW-1:0] END2_2 =
        AW'(CONV2_2_OUTPUT_SIZE * CONV2_2_OUTPUT_SIZE - 1);
    localparam logic [AW-1:0] END3_1 =
        AW'(CONV3_1_OUTPUT_SIZE * CONV3_1_OUTPUT_SIZE - 1);
    localparam logic [AW-1:0] END3_2 =
        AW'(CONV3_2_OUTPUT_SIZE * CONV3_2_OUTPUT_SIZE - 1);

    logic [AW-1:0] end_addr;
    logic          is_conv;

    // Last address of the current conv layer
    always_comb begin
        end_addr = '0;
        is_conv  = 1'b1;
        case (state)
            CONV1_1: end_addr = END1_1;
            CONV1_2: end_addr = END1_2;
            CONV2_1: end_addr = END2_1;
            CONV2_2: end_addr = END2_2;
            CONV3_1: end_addr = END3_1;
            CONV3_2: end_addr = END3_2;
            default: is_conv  = 1'b0;
        endcase
    end

    // Wrap counter; a wrap marks the end of one output pass
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Out_Address <= '0;
        end else if (clear || !is_conv) begin
            Out_Address <= '0;
        end else if (out_valid) begin
            if (Out_Address == end_addr)
                Out_Address <= '0;
            else
                Out_Address <= Out_Address + 1'b1;
        end
    end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Layer scheduler: walks the fixed layer order, publishes
// the state code and owns the conv output address.
module conv_layer_sequencer #(
    parameter int STATE_DATAWIDTH     = conv_pkg::STATE_DATAWIDTH,
    parameter int ADDRESS_DATAWIDTH   = conv_pkg::ADDRESS_DATAWIDTH,
    parameter int CONV1_1_OUTPUT_SIZE = conv_pkg::CONV1_1_OUTPUT_SIZE,
    parameter int CONV1_2_OUTPUT_SIZE = conv_pkg::CONV1_2_OUTPUT_SIZE,
    parameter int CONV2_1_OUTPUT_SIZE = conv_pkg::CONV2_1_OUTPUT_SIZE,
    parameter int CONV2_2_OUTPUT_SIZE = conv_pkg::CONV2_2_OUTPUT_SIZE,
    parameter int CONV3_1_OUTPUT_SIZE = conv_pkg::CONV3_1_OUTPUT_SIZE,
    parameter int CONV3_2_OUTPUT_SIZE = conv_pkg::CONV3_2_OUTPUT_SIZE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         load_done,
    input  logic                         out_valid,
    input  logic                         conv_done,
    input  logic                         pool_done,
    input  logic                         fc_done,
    output logic [STATE_DATAWIDTH-1:0]   state,
    output logic [ADDRESS_DATAWIDTH-1:0] Out_Address,
    output logic                         layer_start,
    output logic                         busy,
    output logic                         frame_done
);
    import conv_pkg::*;

    logic [STATE_DATAWIDTH-1:0] state_nxt;
    logic                       clear;

    // Next layer; completions outside their layer are ignored
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = LOAD;
            LOAD:    if (load_done) state_nxt = CONV1_1;
            CONV1_1, CONV1_2,
            CONV2_1, CONV2_2,
            CONV3_1, CONV3_2:
                     if (conv_done) state_nxt = state + 1'b1;
            POOL1, POOL2, POOL3:
                     if (pool_done) state_nxt = state + 1'b1;
            FC:      if (fc_done)   state_nxt = FINISH;
            FINISH:                 state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
        if (abort)
            state_nxt = IDLE;
    end

    // Any layer change restarts the address count
    assign clear = (state_nxt != state);
    assign busy  = (state != IDLE);

    // Layer register with registered start/done pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            layer_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            layer_start <= clear && (state_nxt != IDLE);
            frame_done  <= (state_nxt == FINISH);
        end
    end

    conv_addr_counter #(
        .STATE_DATAWIDTH    (STATE_DATAWIDTH),
        .ADDRESS_DATAWIDTH  (ADDRESS_DATAWIDTH),
        .CONV1_1_OUTPUT_SIZE(CONV1_1_OUTPUT_SIZE),
        .CONV1_2_OUTPUT_SIZE(CONV1_2_OUTPUT_SIZE),
        .CONV2_1_OUTPUT_SIZE(CONV2_1_OUTPUT_SIZE),
        .CONV2_2_OUTPUT_SIZE(CONV2_2_OUTPUT_SIZE),
        .CONV3_1_OUTPUT_SIZE(CONV3_1_OUTPUT_SIZE),
        .CONV3_2_OUTPUT_SIZE(CONV3_2_OUTPUT_SIZE)
    ) u_addr (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .out_valid  (out_valid),
        .clear      (clear),
        .Out_Address(Out_Address)
    );

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: layer-order model checked
// every cycle, plus directed literal checks.
module tb_conv_layer_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        load_done = 1'b0;
    logic        out_valid = 1'b0;
    logic        conv_done = 1'b0;
    logic        pool_done = 1'b0;
    logic        fc_done = 1'b0;
    logic [3:0]  state;
    logic [12:0] Out_Address;
    logic        layer_start;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    conv_layer_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .load_done  (load_done),
        .out_valid  (out_valid),
        .conv_done  (conv_done),
        .pool_done  (pool_done),
        .fc_done    (fc_done),
        .state      (state),
        .Out_Address(Out_Address),
        .layer_start(layer_start),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int tests = 0;
    int fails = 0;

    int m_state = 0;
    int m_addr  = 0;
    int m_ls    = 0;
    int m_fd    = 0;

    bit rec = 1'b0;
    int visits[$];
    int ls_cnt = 0;
    int fd_cnt = 0;
    int prev_state = 0;

    // Output side length of each conv layer, 0 for the rest
    function automatic int side(int s);
        case (s)
            2: return 82;
            3: return 80;
            5: return 38;
            6: return 36;
            8: return 16;
            9: return 14;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_pool(int s);
        return (s == 4) || (s == 7) || (s == 10);
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d",
                     name, act, exp);
        end
    endtask

    // Asynchronous reset clears the model at once
    always @(posedge reset) begin
        m_state = 0;
        m_addr  = 0;
        m_ls    = 0;
        m_fd    = 0;
    end

    // Model step on each edge, then compare just after it
    always @(posedge clk) begin : model
        int old;
        int nxt;
        if (reset) begin
            m_state = 0;
            m_addr  = 0;
            m_ls    = 0;
            m_fd    = 0;
        end else begin
            old = m_state;
            nxt = old;
            if (abort)
                nxt = 0;
            else if (old > 12)
                nxt = 0;
            else if (old == 0 && start)
                nxt = 1;
            else if (old == 1 && load_done)
                nxt = 2;
            else if (side(old) != 0 && conv_done)
                nxt = old + 1;
            else if (is_pool(old) && pool_done)
                nxt = old + 1;
            else if (old == 11 && fc_done)
                nxt = 12;
            else if (old == 12)
                nxt = 0;
            if (nxt != old)
                m_addr = 0;
            else if (side(old) != 0 && out_valid)
                m_addr = (m_addr + 1) % (side(old) * side(old));
            m_ls    = (nxt != old && nxt != 0) ? 1 : 0;
            m_fd    = (nxt == 12) ? 1 : 0;
            m_state = nxt;
        end
        #1;
        chk("state", int'(state), m_state);
        chk("Out_Address", int'(Out_Address), m_addr);
        chk("layer_start", int'(layer_start), m_ls);
        chk("busy", int'(busy), (m_state != 0) ? 1 : 0);
        chk("frame_done", int'(frame_done), m_fd);
        if (rec) begin
            if (int'(state) != prev_state)
                visits.push_back(int'(state));
            ls_cnt += int'(layer_start);
            fd_cnt += int'(frame_done);
        end
        prev_state = int'(state);
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    // Fire whatever ends the model's current layer
    task automatic adv();
        int s;
        s = m_state;
        if (s == 12) begin
            cyc(1);
            return;
        end
        cyc((s == 1) ? 5 : 3);
        if (s == 0)
            start = 1'b1;
        else if (s == 1)
            load_done = 1'b1;
        else if (s == 11)
            fc_done = 1'b1;
        else if (is_pool(s))
            pool_done = 1'b1;
        else
            conv_done = 1'b1;
        cyc(1);
        start     = 1'b0;
        load_done = 1'b0;
        conv_done = 1'b0;
        pool_done = 1'b0;
        fc_done   = 1'b0;
    endtask

    task automatic run_to(int target);
        int guard;
        guard = 0;
        while (m_state != target && guard < 20) begin
            adv();
            guard++;
        end
        chk("run_to", int'(state), target);
    endtask

    task automatic full_frame(string tag);
        visits.delete();
        ls_cnt = 0;
        fd_cnt = 0;
        rec = 1'b1;
        run_to(12);
        adv();
        cyc(1);
        rec = 1'b0;
        chk({tag, "_visits"}, visits.size(), 13);
        for (int i = 0; i < 13; i++) begin
            if (i < visits.size())
                chk({tag, "_visit"}, visits[i],
                    (i == 12) ? 0 : i + 1);
        end
        chk({tag, "_layer_starts"}, ls_cnt, 12);
        chk({tag, "_frame_dones"}, fd_cnt, 1);
    endtask

    initial begin
        cyc(2);
        chk("rst_state", int'(state), 0);
        chk("rst_addr", int'(Out_Address), 0);
        chk("rst_layer_start", int'(layer_start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        reset = 1'b0;
        cyc(2);

        full_frame("frame1");

        run_to(2);
        out_valid = 1'b1;
        cyc(6723);
        chk("c11_last", int'(Out_Address), 6723);
        cyc(1);
        chk("c11_wrap", int'(Out_Address), 0);
        chk("c11_stay", int'(state), 2);
        out_valid = 1'b0;
        cyc(3);
        chk("c11_hold", int'(Out_Address), 0);

        run_to(5);
        pool_done = 1'b1;
        fc_done   = 1'b1;
        cyc(1);
        pool_done = 1'b0;
        fc_done   = 1'b0;
        cyc(1);
        chk("stray_done", int'(state), 5);

        run_to(7);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        chk("stray_start", int'(state), 7);

        run_to(9);
        out_valid = 1'b1;
        cyc(195);
        chk("c32_last", int'(Out_Address), 195);
        cyc(1);
        chk("c32_wrap", int'(Out_Address), 0);
        cyc(195);
        chk("c32_last2", int'(Out_Address), 195);
        conv_done = 1'b1;
        cyc(1);
        conv_done = 1'b0;
        out_valid = 1'b0;
        chk("coinc_state", int'(state), 10);
        chk("coinc_addr", int'(Out_Address), 0);
        chk("coinc_ls", int'(layer_start), 1);

        run_to(12);
        chk("finish_fd", int'(frame_done), 1);
        start = 1'b1;
        cyc(2);
        start = 1'b0;
        chk("start_thru_finish", int'(state), 1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort_load", int'(state), 0);

        run_to(6);
        out_valid = 1'b1;
        cyc(700);
        chk("c22_addr", int'(Out_Address), 700);
        out_valid = 1'b0;
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort_state", int'(state), 0);
        chk("abort_addr", int'(Out_Address), 0);
        chk("abort_busy", int'(busy), 0);

        run_to(11);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_addr", int'(Out_Address), 0);
        chk("arst_layer_start", int'(layer_start), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_frame_done", int'(frame_done), 0);
        #1;
        reset = 1'b0;
        cyc(3);
        chk("arst_idle", int'(state), 0);

        full_frame("frame2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Top-level layer scheduler for the convolution accelerator. It steps the network through its fixed layer order: load, conv1_1/1_2, pool1, conv2_x, pool2, conv3_x, pool3, fc. It publishes the `state` code that the convolution controller, pooling and FC blocks decode. It also owns the conv output address counter (`Out_Address`) those blocks consume, and it advances on their completion signals.

## Interface
Parameters:
- `STATE_DATAWIDTH`, default 4: width of the `state` code.
- `ADDRESS_DATAWIDTH`, default 13: width of `Out_Address`.
- `CONV1_1_OUTPUT_SIZE`, default 82: conv1_1 output side length.
- `CONV1_2_OUTPUT_SIZE`, default 80: conv1_2 output side length.
- `CONV2_1_OUTPUT_SIZE`, default 38: conv2_1 output side length.
- `CONV2_2_OUTPUT_SIZE`, default 36: conv2_2 output side length.
- `CONV3_1_OUTPUT_SIZE`, default 16: conv3_1 output side length.
- `CONV3_2_OUTPUT_SIZE`, default 14: conv3_2 output side length.

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begin one frame; honoured in IDLE only.
- `abort`, input, 1: synchronous return to IDLE from any state.
- `load_done`, input, 1: input image buffer filled.
- `out_valid`, input, 1: conv datapath produced the output at `Out_Address` this cycle.
- `conv_done`, input, 1: conv controller finished all loops and filters of the current layer.
- `pool_done`, input, 1: pooling block finished the current pool layer.
- `fc_done`, input, 1: FC block finished.
- `state`, output, STATE_DATAWIDTH: current layer code.
- `Out_Address`, output, ADDRESS_DATAWIDTH: conv output write address.
- `layer_start`, output, 1: one-cycle pulse in the first cycle of each non-IDLE state.
- `busy`, output, 1: high when `state` is not IDLE.
- `frame_done`, output, 1: one-cycle pulse when the frame completes.

## Operation
State codes (fixed; other blocks decode them): IDLE=0, LOAD=1, CONV1_1=2, CONV1_2=3, POOL1=4, CONV2_1=5, CONV2_2=6, POOL2=7, CONV3_1=8, CONV3_2=9, POOL3=10, FC=11, FINISH=12. Codes 13–15 are illegal and go to IDLE on the next edge.

Transitions:
- IDLE→LOAD on `start`.
- LOAD→CONV1_1 on `load_done`.
- Each conv state advances to the next code on `conv_done`: 2→3→4, 5→6→7, 8→9→10.
- Each POOL state advances on `pool_done`: 4→5, 7→8, 10→11.
- FC→FINISH on `fc_done`.
- FINISH→IDLE unconditionally after 1 cycle.

Completion-signal rules:
- A completion signal arriving outside its matching state is ignored.
- `abort` has priority over every transition. It forces IDLE and clears `Out_Address` to 0.

Address counter:
- Out_Address_End = SIZE*SIZE−1 for the current conv state (6723, 6399, 1443, 1295, 255, 195). Compute it at full product width, then compare at ADDRESS_DATAWIDTH.
- In a conv state, on `out_valid`: if `Out_Address`==End it wraps to 0, otherwise it increments by 1. The wrap marks a pass boundary; the conv controller counts loops and filters.
- `Out_Address` holds when `out_valid`=0.
- `Out_Address` is forced to 0 on every state change and held at 0 in non-conv states.
- If `conv_done` and `out_valid` coincide, the state advances and `Out_Address` goes to 0.

## Timing
- Reset values: `state`=0, `Out_Address`=0, `layer_start`=0, `busy`=0, `frame_done`=0.
- `state`, `Out_Address`, `layer_start` and `frame_done` are registered. `busy` is decoded from the registered `state`.
- A transition takes effect on the edge where its condition is sampled high. `state` shows the new code in the following cycle, with `layer_start`=1 in that same cycle.
- `frame_done`=1 exactly during the FINISH cycle. `busy` stays 1 in FINISH.
- `start` held high across FINISH→IDLE launches the next frame on the first IDLE edge. `start` is ignored while `busy`=1.
- Reset asserted mid-frame returns all outputs to reset values immediately (asynchronous). After release, operation resumes only on a new `start`.

## Structure
- Shared package `conv_pkg` holds:
  - the state code localparams (IDLE…FINISH), also used by the conv controller, pooling and FC blocks;
  - the layer output-size constants;
  - STATE_DATAWIDTH and ADDRESS_DATAWIDTH.
- Sub-module `conv_addr_counter` holds the End lookup plus the wrap counter. Its inputs are `state`, `out_valid`, `clear`; its output is `Out_Address`. The sequencer FSM drives `clear`.

## Test plan
- Full frame: `start`; `load_done` after 5 cycles; each completion signal pulsed after N cycles → `state` visits 1,2,3,4,5,6,7,8,9,10,11,12,0 in order. Each state gets exactly one `layer_start`; `frame_done` pulses once.
- CONV1_1 with `out_valid` held high for 6724 cycles → `Out_Address` counts 0…6723, then wraps to 0. Repeat for CONV3_2 → 0…195, wrap to 0.
- `conv_done` coincident with `out_valid` at `Out_Address`=195 in CONV3_2 → next cycle `state`=10, `Out_Address`=0.
- Stray `pool_done`/`fc_done` pulses during CONV2_1, and `start` during POOL2 → no state change.
- `abort` in CONV2_2 at `Out_Address`=700 → next cycle `state`=0, `Out_Address`=0, `busy`=0.
- Async `reset` pulse between clock edges during FC → outputs 0 immediately; a later `start` runs a clean frame.
